// File: rtl/cac_actuator_driver.sv
// Actuator driver: command FSM with watchdog, slewed motor duty and steering,
// PWM generation and blinking indicator / hazard lamps.
module cac_actuator_driver #(
    parameter int WDOG_LIMIT = 16,
    parameter int BLINK_HALF = 8,
    parameter int STEER_STEP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] acceleration,
    input  logic [1:0] steering,
    input  logic [1:0] indicators,
    input  logic       clear_fault,
    output logic       motor_pwm,
    output logic       brake_en,
    output logic [7:0] duty,
    output logic [7:0] steer_angle,
    output logic       lamp_left,
    output logic       lamp_right,
    output logic [1:0] state,
    output logic       fault
);
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN      = 2'b01,
        FAILSAFE = 2'b10,
        FAULT    = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        LAMP_OFF, LAMP_LEFT, LAMP_RIGHT, LAMP_HAZARD
    } lamp_t;

    localparam int WW = $clog2(WDOG_LIMIT + 1);
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic signed [9:0] STEP = 10'(STEER_STEP);

    state_t               st, st_nx;
    logic [1:0]           acc_r, str_r, ind_r;
    logic [WW-1:0]        wdog_cnt, wdog_nx;
    logic [7:0]           pwm_cnt;
    logic [BW-1:0]        blink_cnt, blink_nx;
    logic                 phase, phase_nx;
    lamp_t                mode, mode_r;
    logic                 accept, legal;
    logic [7:0]           duty_tgt, duty_nx;
    logic signed [9:0]    steer_tgt, steer_cur, steer_nx;

    assign accept = cmd_valid & cmd_ready;
    assign legal  = (acceleration != 2'b11) && (steering != 2'b11)
                 && (indicators != 2'b11);
    assign state  = st;
    assign steer_cur = {{2{steer_angle[7]}}, steer_angle};

    // FSM next state and watchdog
    always_comb begin
        st_nx   = st;
        wdog_nx = '0;
        if (accept && !legal) begin
            st_nx = FAULT;
        end else begin
            case (st)
                IDLE:     if (accept) st_nx = RUN;
                RUN: begin
                    if (!accept) begin
                        if (wdog_cnt == WW'(WDOG_LIMIT)) st_nx = FAILSAFE;
                        else wdog_nx = wdog_cnt + 1'b1;
                    end
                end
                FAILSAFE: if (accept && duty == 8'd0) st_nx = RUN;
                FAULT:    if (clear_fault) st_nx = IDLE;
                default:  st_nx = IDLE;
            endcase
        end
    end

    // Motion targets only apply while running
    always_comb begin
        duty_tgt  = 8'd0;
        steer_tgt = 10'sd0;
        if (st == RUN) begin
            case (acc_r)
                2'b10:   duty_tgt = 8'd200;
                2'b01:   duty_tgt = duty;
                default: duty_tgt = 8'd0;
            endcase
            case (str_r)
                2'b01:   steer_tgt = -10'sd64;
                2'b10:   steer_tgt = 10'sd64;
                default: steer_tgt = 10'sd0;
            endcase
        end
    end

    always_comb begin
        duty_nx = duty;
        if (duty < duty_tgt)
            duty_nx = (duty_tgt - duty > 8'd4) ? duty + 8'd4 : duty_tgt;
        else if (duty > duty_tgt)
            duty_nx = (duty - duty_tgt > 8'd8) ? duty - 8'd8 : duty_tgt;
        steer_nx = steer_tgt;
        if (steer_tgt - steer_cur > STEP)
            steer_nx = steer_cur + STEP;
        else if (steer_cur - steer_tgt > STEP)
            steer_nx = steer_cur - STEP;
    end

    // Lamp mode; any change restarts the blink with the lamp on
    always_comb begin
        mode = LAMP_OFF;
        if (st == FAILSAFE || st == FAULT) begin
            mode = LAMP_HAZARD;
        end else if (st == RUN) begin
            if (ind_r == 2'b01) mode = LAMP_LEFT;
            else if (ind_r == 2'b10) mode = LAMP_RIGHT;
        end
        blink_nx = blink_cnt + 1'b1;
        phase_nx = phase;
        if (mode != mode_r) begin
            blink_nx = '0;
            phase_nx = 1'b1;
        end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
            blink_nx = '0;
            phase_nx = ~phase;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= IDLE;
            acc_r       <= 2'b00;
            str_r       <= 2'b00;
            ind_r       <= 2'b00;
            wdog_cnt    <= '0;
            pwm_cnt     <= 8'd0;
            duty        <= 8'd0;
            steer_angle <= 8'd0;
            motor_pwm   <= 1'b0;
            brake_en    <= 1'b1;
            blink_cnt   <= '0;
            phase       <= 1'b0;
            mode_r      <= LAMP_OFF;
            lamp_left   <= 1'b0;
            lamp_right  <= 1'b0;
            cmd_ready   <= 1'b1;
            fault       <= 1'b0;
        end else begin
            st <= st_nx;
            if (accept && legal) begin
                acc_r <= acceleration;
                str_r <= steering;
                ind_r <= indicators;
            end
            wdog_cnt    <= wdog_nx;
            pwm_cnt     <= pwm_cnt + 8'd1;
            duty        <= duty_nx;
            steer_angle <= steer_nx[7:0];
            motor_pwm   <= pwm_cnt < duty;
            brake_en    <= (duty_tgt == 8'd0 && duty == 8'd0) || st != RUN;
            blink_cnt   <= blink_nx;
            phase       <= phase_nx;
            mode_r      <= mode;
            lamp_left   <= phase_nx
                        & (mode == LAMP_LEFT || mode == LAMP_HAZARD);
            lamp_right  <= phase_nx
                        & (mode == LAMP_RIGHT || mode == LAMP_HAZARD);
            cmd_ready   <= st_nx != FAULT;
            fault       <= st_nx == FAULT;
        end
    end
endmodule

// File: tb/tb_cac_actuator_driver.sv
// Randomised and directed bench for cac_actuator_driver against a
// cycle-level behavioural model of the actuator rules.
module tb_cac_actuator_driver;
    localparam int WL = 16;
    localparam int BH = 8;
    localparam int SS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       clear_fault = 1'b0;
    logic [1:0] acceleration = 2'b00;
    logic [1:0] steering = 2'b00;
    logic [1:0] indicators = 2'b00;
    logic       cmd_ready, motor_pwm, brake_en;
    logic [7:0] duty, steer_angle;
    logic       lamp_left, lamp_right, fault;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    // model state
    int ms, macc, mstr, mind, mwd, mpwm, mduty, msteer;
    int mmotor, mbrake, mll, mlr, mfault, mready, mmode_prev, mage;

    cac_actuator_driver #(
        .WDOG_LIMIT(WL), .BLINK_HALF(BH), .STEER_STEP(SS)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .acceleration(acceleration), .steering(steering),
        .indicators(indicators), .clear_fault(clear_fault),
        .motor_pwm(motor_pwm), .brake_en(brake_en),
        .duty(duty), .steer_angle(steer_angle),
        .lamp_left(lamp_left), .lamp_right(lamp_right),
        .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, $signed(got), $signed(exp), $time);
        end
    endtask

    task automatic model_reset();
        ms = 0; macc = 0; mstr = 0; mind = 0; mwd = 0; mpwm = 0;
        mduty = 0; msteer = 0; mmotor = 0; mbrake = 1; mll = 0; mlr = 0;
        mfault = 0; mready = 1; mmode_prev = 0; mage = 0;
    endtask

    task automatic model_step();
        int dt, stt, mode, ns, old_duty;
        bit acc, legal;
        acc = cmd_valid && (mready != 0);
        legal = acceleration != 3 && steering != 3 && indicators != 3;
        old_duty = mduty;
        dt = 0; stt = 0; mode = 0;
        if (ms == 1) begin
            if (macc == 2) dt = 200;
            else if (macc == 1) dt = mduty;
            if (mstr == 1) stt = -64;
            else if (mstr == 2) stt = 64;
            mode = mind;
        end else if (ms >= 2) begin
            mode = 3;
        end
        mmotor = (mpwm < mduty) ? 1 : 0;
        mbrake = ((dt == 0 && mduty == 0) || ms != 1) ? 1 : 0;
        mpwm = (mpwm + 1) % 256;
        if (mduty < dt) mduty = (dt - mduty > 4) ? mduty + 4 : dt;
        else if (mduty > dt) mduty = (mduty - dt > 8) ? mduty - 8 : dt;
        if (msteer < stt) msteer = (stt - msteer > SS) ? msteer + SS : stt;
        else if (msteer > stt) msteer = (msteer - stt > SS) ? msteer - SS : stt;
        // time since the lamp mode last changed decides the blink phase
        if (mode != mmode_prev) mage = 0;
        else mage = (mage + 1) % (2 * BH);
        mmode_prev = mode;
        mll = (mage < BH && (mode == 1 || mode == 3)) ? 1 : 0;
        mlr = (mage < BH && (mode == 2 || mode == 3)) ? 1 : 0;
        ns = ms;
        if (acc && !legal) ns = 3;
        else case (ms)
            0: if (acc) ns = 1;
            1: begin
                if (acc) mwd = 0;
                else if (mwd == WL) ns = 2;
                else mwd++;
            end
            2: if (acc && old_duty == 0) ns = 1;
            default: if (clear_fault) ns = 0;
        endcase
        if (ns != 1) mwd = 0;
        if (acc && legal) begin
            macc = acceleration; mstr = steering; mind = indicators;
        end
        ms = ns;
        mfault = (ns == 3) ? 1 : 0;
        mready = (ns != 3) ? 1 : 0;
    endtask

    task automatic compare();
        check("state", 32'(state), ms);
        check("duty", 32'(duty), mduty);
        check("steer_angle", 32'($signed(steer_angle)), msteer);
        check("motor_pwm", 32'(motor_pwm), mmotor);
        check("brake_en", 32'(brake_en), mbrake);
        check("lamp_left", 32'(lamp_left), mll);
        check("lamp_right", 32'(lamp_right), mlr);
        check("fault", 32'(fault), mfault);
        check("cmd_ready", 32'(cmd_ready), mready);
    endtask

    task automatic cycle(input bit v, input bit [1:0] a, input bit [1:0] s,
                         input bit [1:0] i, input bit cf);
        cmd_valid = v; acceleration = a; steering = s;
        indicators = i; clear_fault = cf;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1 model_reset();
        compare();
        #1 rst = 1'b0;
    endtask

    function automatic bit [1:0] rnd_code();
        if ($urandom_range(0, 19) == 0) return 2'b11;
        return 2'($urandom_range(0, 2));
    endfunction

    initial begin
        int high;
        model_reset();
        #2 rst = 1'b1;
        #1 compare();
        @(negedge clk);
        compare();
        #1 rst = 1'b0;

        // accelerate to full duty with periodic keep-alives
        cycle(1, 2, 0, 0, 0);
        check("run_after_accept", 32'(state), 1);
        for (int k = 0; k < 60; k++) cycle(k % 10 == 9, 2, 0, 0, 0);
        check("duty_full", 32'(duty), 200);
        check("brake_off", 32'(brake_en), 0);
        high = 0;
        for (int k = 0; k < 256; k++) begin
            cycle(k % 10 == 9, 2, 0, 0, 0);
            high += int'(motor_pwm);
        end
        check("pwm_high_count", high, 200);

        // steer left, left indicator
        cycle(1, 1, 1, 1, 0);
        for (int k = 0; k < 40; k++) cycle(k % 10 == 9, 1, 1, 1, 0);
        check("steer_left", 32'($signed(steer_angle)), -64);
        check("lamp_right_off", 32'(lamp_right), 0);

        // keep-alive exactly when the watchdog is due
        cycle(1, 1, 0, 0, 0);
        repeat (16) cycle(0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        check("wdog_edge_run", 32'(state), 1);

        // starve the watchdog, then recover from failsafe
        repeat (17) cycle(0, 0, 0, 0, 0);
        check("failsafe", 32'(state), 2);
        repeat (30) cycle(0, 0, 0, 0, 0);
        check("failsafe_brake", 32'(brake_en), 1);
        check("failsafe_duty", 32'(duty), 0);
        cycle(1, 0, 0, 0, 0);
        check("failsafe_exit", 32'(state), 1);

        // illegal command, ignored commands, clear
        cycle(1, 3, 0, 0, 0);
        check("fault_flag", 32'(fault), 1);
        check("fault_ready", 32'(cmd_ready), 0);
        repeat (5) cycle(1, 2, 0, 0, 0);
        check("fault_hold", 32'(state), 3);
        cycle(1, 2, 0, 0, 1);
        check("fault_clear", 32'(state), 0);

        // reset in the middle of a slew
        cycle(1, 2, 0, 0, 0);
        for (int k = 0; k < 19; k++) cycle(k == 9, 2, 0, 0, 0);
        cycle(1, 2, 2, 0, 0);
        repeat (10) cycle(0, 0, 0, 0, 0);
        check("mid_duty", 32'(duty), 120);
        check("mid_steer", 32'($signed(steer_angle)), 40);
        do_reset();
        check("rst_duty", 32'(duty), 0);
        check("rst_steer", 32'(steer_angle), 0);
        check("rst_state", 32'(state), 0);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            cycle($urandom_range(0, 7) == 0, rnd_code(), rnd_code(),
                  rnd_code(), $urandom_range(0, 7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/cac_actuator_driver.md
CAC_ACTUATOR_DRIVER -- requirements
Module: cac_actuator_driver

Interface
REQ-001 SHALL have parameter WDOG_LIMIT, default 16: number of RUN cycles without an accepted command before FAILSAFE is entered.
REQ-002 SHALL have parameter BLINK_HALF, default 8: number of cycles a lamp spends on, and then off, per blink phase.
REQ-003 SHALL have parameter STEER_STEP, default 4: maximum steer_angle change per cycle.
REQ-004 SHALL have ports clk in 1 (clock) and rst in 1 (reset); reset rst, asynchronous, active-high; clock clk.
REQ-005 SHALL have ports cmd_valid in 1 (command strobe) and cmd_ready out 1 (command accepted when both are high).
REQ-006 SHALL have port acceleration in 2: 10 = accelerate, 01 = hold, 00 = brake, 11 = illegal.
REQ-007 SHALL have port steering in 2: 00 = straight, 01 = left, 10 = right, 11 = illegal.
REQ-008 SHALL have port indicators in 2: 00 = off, 01 = left, 10 = right, 11 = illegal.
REQ-009 SHALL have port clear_fault in 1: pulse that exits FAULT.
REQ-010 SHALL have ports motor_pwm out 1 (motor drive) and brake_en out 1 (brake actuator).
REQ-011 SHALL have ports duty out 8 (unsigned motor duty) and steer_angle out 8 (signed two's complement; negative = left).
REQ-012 SHALL have ports lamp_left out 1, lamp_right out 1, state out 2 (00 IDLE, 01 RUN, 10 FAILSAFE, 11 FAULT) and fault out 1.

Function
REQ-013 SHALL drive cmd_ready = 1 in every state except FAULT; accept = cmd_valid & cmd_ready.
REQ-014 SHALL, on accept with all three codes legal, latch the codes into command registers at that edge; the new targets take effect from the next edge.
REQ-015 SHALL treat an accept where any code equals 11 as illegal: enter FAULT at that edge; command registers unchanged.
REQ-016 SHALL implement the FSM as follows:
- IDLE -> RUN on legal accept.
- RUN -> FAILSAFE when wdog_cnt == WDOG_LIMIT and there is no accept that cycle.
- FAILSAFE -> RUN on legal accept while duty == 0 (a legal accept with duty != 0 is latched but the state stays FAILSAFE).
- Any state -> FAULT on illegal accept.
- FAULT -> IDLE on clear_fault, which has priority over cmd_valid.
REQ-017 SHALL keep wdog_cnt at 0 on accept and outside RUN; it SHALL increment by 1 per RUN cycle otherwise, saturating at WDOG_LIMIT.
REQ-018 SHALL let an accept in the same cycle the watchdog would expire win: state stays RUN and wdog_cnt clears.
REQ-019 SHALL set the duty target in RUN to 200 for accel 10, the current duty for 01, and 0 for 00; in IDLE, FAILSAFE and FAULT the target SHALL be 0.
REQ-020 SHALL slew duty toward its target by +4 or -8 per cycle, clamped so it never passes the target; duty SHALL be 0..200.
REQ-021 SHALL run pwm_cnt as an 8-bit free-running counter that wraps 255 -> 0; motor_pwm = (pwm_cnt < duty), registered.
REQ-022 SHALL drive brake_en = 1 when the duty target is 0 and duty is 0, or when state != RUN; otherwise brake_en = 0.
REQ-023 SHALL set the steer target to 0 for 00, -64 for 01 and +64 for 10 in RUN, and to 0 in all other states.
REQ-024 SHALL move steer_angle by at most STEER_STEP per cycle toward the target, with no overshoot and no sign wrap.
REQ-025 SHALL blink lamps as follows:
- A blink counter counts 0..BLINK_HALF-1; the phase toggles at wrap.
- indicators 01 in RUN: lamp_left = phase, lamp_right = 0.
- indicators 10 in RUN: lamp_right = phase, lamp_left = 0.
- indicators 00: both lamps 0.
REQ-026 SHALL drive both lamps = phase (hazards) in FAILSAFE and FAULT.
REQ-027 SHALL restart the blink counter with phase = on whenever the effective lamp mode changes.
REQ-028 SHALL drive fault = 1 exactly when state == FAULT.
REQ-029 SHALL register all outputs.

Reset
REQ-030 SHALL, on rst, force within the same cycle: state IDLE, command registers 00/00/00, wdog_cnt 0, pwm_cnt 0, duty 0, steer_angle 0, motor_pwm 0, brake_en 1, lamps 0, fault 0, cmd_ready 1.
REQ-031 SHALL abort any slew, blink or watchdog count when rst asserts mid-operation; there is no resume.

Verification
REQ-032 Reset, then accept {10,00,00} -> state RUN; duty 0, 4, 8 ... reaching 200 after 50 cycles; brake_en 0; motor_pwm high for 200 of every 256 cycles.
REQ-033 Accept {01,01,01} in RUN -> steer_angle 0, -4, ... -64 in 16 cycles; lamp_left toggles every 8 cycles; lamp_right 0.
REQ-034 Accept at cycle t, then no cmd_valid -> FAILSAFE at the 17th edge after t; duty falls 8/cycle to 0; hazards blink; brake_en 1; a legal accept after duty hits 0 -> RUN.
REQ-035 Accept with acceleration 11 -> FAULT and fault 1 at the next edge; cmd_ready 0; cmd_valid ignored; clear_fault together with cmd_valid -> IDLE.
REQ-036 Accept in the same cycle wdog_cnt == 16 -> state stays RUN and wdog_cnt reads 0.
REQ-037 Assert rst mid-slew with duty at 120 and steer_angle at +40 -> duty 0, steer_angle 0, IDLE immediately.
